// File: rtl/led_mask_pkg.sv
// ---------------------------------------------------------------------------
// led_mask_pkg
//   Shared sizing constants and types for the masked LED SubCells sequencer.
//   SLICES is the number of 8-bit slices per 64-bit share. Each issued slice
//   carries a tag, which is its slice index. The tag travels alongside the
//   S-box core latency so that results land in the right byte.
// ---------------------------------------------------------------------------
package led_mask_pkg;

  localparam int STATE_W  = 64;
  localparam int SLICE_W  = 8;
  localparam int SLICES   = STATE_W / SLICE_W;
  localparam int SBOX_LAT = 3;
  localparam int RND_W    = 90;
  localparam int SHARES   = 3;

  localparam int TAG_W = $clog2(SLICES);
  // One extra bit so the counters can hold the terminal value SLICES.
  localparam int CNT_W = $clog2(SLICES + 1);

  localparam logic [CNT_W-1:0] SLICES_CNT = CNT_W'(SLICES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ctrl_state_e;

  typedef logic [TAG_W-1:0] tag_t;

  // One in-flight slot of the S-box core: valid marks a real slice, not a bubble.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } slot_t;

endpackage

// File: rtl/led_masked_subcells_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_masked_subcells_ctrl_if
//   Bus between the SubCells sequencer and the external masked S-box core.
//   master (sequencer): drives sb_in1..3 (one slice per share) and sb_r
//                       (fresh randomness); receives sb_out1..3.
//   slave  (S-box core): the mirror image.
//   Each share has its own lanes. Nothing in this bus mixes shares.
// ---------------------------------------------------------------------------
interface led_masked_subcells_ctrl_if;
  import led_mask_pkg::*;

  logic [SLICE_W-1:0] sb_in1;
  logic [SLICE_W-1:0] sb_in2;
  logic [SLICE_W-1:0] sb_in3;
  logic [RND_W-1:0]   sb_r;
  logic [SLICE_W-1:0] sb_out1;
  logic [SLICE_W-1:0] sb_out2;
  logic [SLICE_W-1:0] sb_out3;

  modport master (
    output sb_in1, sb_in2, sb_in3, sb_r,
    input  sb_out1, sb_out2, sb_out3
  );

  modport slave (
    input  sb_in1, sb_in2, sb_in3, sb_r,
    output sb_out1, sb_out2, sb_out3
  );

endinterface

// File: rtl/slot_tag_pipe.sv
// ---------------------------------------------------------------------------
// slot_tag_pipe
//   A shift register, SBOX_LAT deep, of {valid, tag}. It runs in lockstep with
//   the S-box core, which has no enable. The head entry describes the core
//   output that is present in the current cycle.
//   Ports:
//     clk, rst  clock and synchronous active-high clear of every slot
//     slot_i    slot pushed this cycle (valid=0 for a bubble)
//     slot_o    slot whose result is on the core outputs now
// ---------------------------------------------------------------------------
module slot_tag_pipe
  import led_mask_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  slot_t slot_i,
  output slot_t slot_o
);

  generate
    for (genvar gi = 0; gi < SBOX_LAT; gi++) begin : g_stage
      slot_t stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) stage_q <= '0;
          else     stage_q <= slot_i;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) stage_q <= '0;
          else     stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign slot_o = g_stage[SBOX_LAT-1].stage_q;

endmodule

// File: rtl/led_masked_subcells_ctrl.sv
// ---------------------------------------------------------------------------
// led_masked_subcells_ctrl
//   Sequencer for the LED SubCells layer on a 3-share 64-bit state. In each
//   cycle where randomness is available, it issues one 8-bit slice per share
//   to the external masked S-box core. It then collects the core's delayed
//   results back into three 64-bit result registers.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     start_i                  begin a layer (honoured only in IDLE)
//     state_in1_i..3_i         input shares, latched with start_i
//     rnd_in_i / rnd_valid_i   PRNG word and its freshness flag
//     rnd_ack_o                word consumed this cycle (a slice was issued)
//     sb                       master side of the S-box core bus
//     busy_o                   layer in progress (ISSUE or DRAIN)
//     done_o                   one-cycle pulse when all results are captured
//     state_out1_o..3_o        substituted shares, held until overwritten
// ---------------------------------------------------------------------------
module led_masked_subcells_ctrl
  import led_mask_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [STATE_W-1:0]  state_in1_i,
  input  logic [STATE_W-1:0]  state_in2_i,
  input  logic [STATE_W-1:0]  state_in3_i,
  input  logic [RND_W-1:0]    rnd_in_i,
  input  logic                rnd_valid_i,
  output logic                rnd_ack_o,
  led_masked_subcells_ctrl_if.master sb,
  output logic                busy_o,
  output logic                done_o,
  output logic [STATE_W-1:0]  state_out1_o,
  output logic [STATE_W-1:0]  state_out2_o,
  output logic [STATE_W-1:0]  state_out3_o
);

  ctrl_state_e       state_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  issue_cnt_d;
  logic [CNT_W-1:0]  coll_cnt_q;
  logic [CNT_W-1:0]  coll_cnt_d;
  logic              busy_q;
  logic              done_q;

  logic              load;
  logic              issue;
  logic              capture;
  slot_t             push_slot;
  slot_t             head_slot;

  logic [STATE_W-1:0] state_in_w [SHARES];
  logic [SLICE_W-1:0] sb_out_w   [SHARES];
  logic [SLICE_W-1:0] sb_in_w    [SHARES];
  logic [STATE_W-1:0] result_w   [SHARES];

  // Issue is gated by state. This way rnd_valid outside ISSUE never consumes
  // randomness and never pushes a valid slot.
  assign load    = (state_q == IDLE) && start_i;
  assign issue   = (state_q == ISSUE) && rnd_valid_i;
  assign capture = head_slot.valid && ((state_q == ISSUE) || (state_q == DRAIN));

  assign issue_cnt_d = issue_cnt_q + CNT_W'(issue);
  assign coll_cnt_d  = coll_cnt_q + CNT_W'(capture);

  // A bubble pushes an all-zero slot, so the tag carries no stale index.
  assign push_slot = {issue, (issue ? issue_cnt_q[TAG_W-1:0] : TAG_W'(0))};

  slot_tag_pipe u_slot_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .slot_i (push_slot),
    .slot_o (head_slot)
  );

  // Control FSM. The transitions look at the post-increment counts. As a
  // result, DRAIN starts right after the last issue, and DONE starts right
  // after the last capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      coll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= ISSUE;
            issue_cnt_q <= '0;
            coll_cnt_q  <= '0;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          issue_cnt_q <= issue_cnt_d;
          coll_cnt_q  <= coll_cnt_d;
          if (issue_cnt_d == SLICES_CNT) state_q <= DRAIN;
        end
        DRAIN: begin
          coll_cnt_q <= coll_cnt_d;
          if (coll_cnt_d == SLICES_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state_in_w[0] = state_in1_i;
  assign state_in_w[1] = state_in2_i;
  assign state_in_w[2] = state_in3_i;

  assign sb_out_w[0] = sb.sb_out1;
  assign sb_out_w[1] = sb.sb_out2;
  assign sb_out_w[2] = sb.sb_out3;

  // Per-share datapath. Each share has its own shift register and its own
  // result register. The only signals shared between shares are the
  // load/issue/capture strobes and the head tag.
  generate
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
      logic [STATE_W-1:0] shift_q;
      logic [STATE_W-1:0] result_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          shift_q  <= '0;
          result_q <= '0;
        end else begin
          if (load) begin
            shift_q <= state_in_w[gi];
          end else if (issue) begin
            shift_q <= shift_q >> SLICE_W;
          end
          // The result register is not cleared on start. Each byte is
          // overwritten only when its own slice comes back from the core.
          if (capture) begin
            result_q[head_slot.tag*SLICE_W +: SLICE_W] <= sb_out_w[gi];
          end
        end
      end

      // Bubbles drive zeros into the core instead of the pending slice.
      assign sb_in_w[gi]  = issue ? shift_q[SLICE_W-1:0] : '0;
      assign result_w[gi] = result_q;
    end
  endgenerate

  assign sb.sb_in1 = sb_in_w[0];
  assign sb.sb_in2 = sb_in_w[1];
  assign sb.sb_in3 = sb_in_w[2];
  assign sb.sb_r   = rnd_in_i;

  assign rnd_ack_o    = issue;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign state_out1_o = result_w[0];
  assign state_out2_o = result_w[1];
  assign state_out3_o = result_w[2];

endmodule
